// File: rtl/pci_burst_fifo.sv
// Burst FIFO between the PCI and Amiga buses: first-word fall-through, a burst FSM and
// direction-dependent byte-lane reversal on the read side, built only with PCI_BYTE_SWAP_EN.
module pci_burst_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                       CLKP,
  input  logic                       RESET,
  input  logic                       DIR,
  input  logic                       FLUSH,
  input  logic                       wr_valid,
  input  logic                       wr_last,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_be,
  output logic                       wr_ready,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic [DATA_W/8-1:0]        rd_be,
  output logic                       rd_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = DATA_W / 8;

`ifdef PCI_BYTE_SWAP_EN
  localparam logic SWAP_EN = 1'b1;
`else
  localparam logic SWAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [LW-1:0]        level_r;
  logic                 dir_q_r;
  logic                 overflow_r;
  logic [DATA_W-1:0]    data_mem_r [DEPTH];
  logic [BW-1:0]        be_mem_r   [DEPTH];
  logic                 last_mem_r [DEPTH];

  logic                 full_s;
  logic                 wr_fire_s;
  logic                 rd_fire_s;
  logic                 swap_s;
  logic [DATA_W-1:0]    raw_data_s;
  logic [BW-1:0]        raw_be_s;

  function automatic logic [DATA_W-1:0] swap_data(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < BW; i++) begin
      r[8*i +: 8] = d[8*(BW-1-i) +: 8];
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] swap_be(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < BW; i++) begin
      r[i] = b[BW-1-i];
    end
    return r;
  endfunction

  assign full_s      = (level_r == LW'(DEPTH));
  assign wr_ready    = !full_s && (state_r != DRAIN);
  assign rd_valid    = (level_r != '0);
  assign wr_fire_s   = wr_valid && wr_ready;
  assign rd_fire_s   = rd_valid && rd_ready;
  assign level       = level_r;
  assign almost_full = (level_r >= LW'(AFULL_LVL));
  assign overflow    = overflow_r;

  // Read side: fall-through word, reversed only when the feature is built and the burst is Amiga->PCI
  assign swap_s     = SWAP_EN & dir_q_r;
  assign raw_data_s = data_mem_r[rd_ptr_r];
  assign raw_be_s   = be_mem_r[rd_ptr_r];
  assign rd_data    = swap_s ? swap_data(raw_data_s) : raw_data_s;
  assign rd_be      = swap_s ? swap_be(raw_be_s) : raw_be_s;
  assign rd_last    = rd_valid && last_mem_r[rd_ptr_r];

  // Burst FSM next-state; a single-word burst flagged last goes straight to DRAIN
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (wr_fire_s) begin
          state_nxt_s = wr_last ? DRAIN : ACTIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (wr_fire_s && wr_last) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      DRAIN: begin
        if (rd_fire_s && rd_last) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Storage array; not reset, and handshakes in a RESET or FLUSH cycle are dropped
  always_ff @(posedge CLKP) begin
    if (wr_fire_s && !RESET && !FLUSH) begin
      data_mem_r[wr_ptr_r] <= wr_data;
      be_mem_r[wr_ptr_r]   <= wr_be;
      last_mem_r[wr_ptr_r] <= wr_last;
    end
  end

  // Control state: pointers, level, FSM, latched direction and sticky overflow
  always_ff @(posedge CLKP) begin
    if (RESET) begin
      state_r    <= IDLE;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      dir_q_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else if (FLUSH) begin
      state_r    <= IDLE;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_fire_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_fire_s, rd_fire_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
      if (state_r == IDLE && wr_fire_s) begin
        dir_q_r <= DIR;
      end
      if (wr_valid && !wr_ready) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pci_burst_fifo.sv
// Directed bench for pci_burst_fifo: a scoreboard queue holds expected read words and a
// negedge monitor compares every completed read; status outputs are checked inline.
module tb_pci_burst_fifo;

  logic        CLKP = 1'b0;
  logic        RESET, DIR, FLUSH;
  logic        wr_valid, wr_last, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic [3:0]  rd_be;
  logic [3:0]  level;
  logic        almost_full, overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  be;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  pci_burst_fifo #(.DATA_W(32), .DEPTH(8)) dut (
    .CLKP(CLKP), .RESET(RESET), .DIR(DIR), .FLUSH(FLUSH),
    .wr_valid(wr_valid), .wr_last(wr_last), .wr_data(wr_data), .wr_be(wr_be),
    .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_be(rd_be), .rd_last(rd_last),
    .level(level), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 CLKP = ~CLKP;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKP);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] be, input logic last);
    sb.push_back('{d: d, be: be, last: last});
  endtask

  // Expected word of an Amiga->PCI burst: reversed only when the swap is built in
  task automatic push_sw(input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] dsw, input logic [3:0] besw, input logic last);
`ifdef PCI_BYTE_SWAP_EN
    push(dsw, besw, last);
`else
    push(d, be, last);
`endif
  endtask

  task automatic write(input logic [31:0] d, input logic [3:0] be, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_be    = be;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, 64'(wr_ready), 64'd1);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_rd_last"}, 64'(rd_last), 64'd0);
    chk({tag, "_almost_full"}, 64'(almost_full), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_level"}, 64'(level), 64'd0);
  endtask

  // Monitor: every read handshake must match the oldest expected word
  always @(negedge CLKP) begin
    if (!RESET && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got word %0h expected no word", rd_data);
      end else begin
        mon_e = sb.pop_front();
        chk("rd_data", 64'(rd_data), 64'(mon_e.d));
        chk("rd_be", 64'(rd_be), 64'(mon_e.be));
        chk("rd_last", 64'(rd_last), 64'(mon_e.last));
      end
    end
  end

  initial begin
    RESET = 1'b1; DIR = 1'b0; FLUSH = 1'b0;
    wr_valid = 1'b0; wr_last = 1'b0; wr_data = 32'h0; wr_be = 4'h0; rd_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    RESET = 1'b0;

    // Amiga->PCI burst; DIR flipping mid-burst must not change the lane order
    DIR = 1'b1;
    push_sw(32'h11223344, 4'b0011, 32'h44332211, 4'b1100, 1'b0);
    write(32'h11223344, 4'b0011, 1'b0);
    DIR = 1'b0;
    chk("fwft_rd_valid", 64'(rd_valid), 64'd1);
    chk("fwft_level", 64'(level), 64'd1);
    push_sw(32'hAABBCCDD, 4'b0111, 32'hDDCCBBAA, 4'b1110, 1'b1);
    write(32'hAABBCCDD, 4'b0111, 1'b1);
    chk("drain_wr_ready", 64'(wr_ready), 64'd0);
    chk("drain_level", 64'(level), 64'd2);
    rd_ready = 1'b1;
    tick(); tick();
    rd_ready = 1'b0;
    chk("idle_wr_ready", 64'(wr_ready), 64'd1);
    chk("idle_rd_valid", 64'(rd_valid), 64'd0);

    // Three-word PCI->Amiga burst
    for (int i = 0; i < 3; i++) begin
      push(32'hC0DE0000 + 32'(i), 4'hF, (i == 2));
      write(32'hC0DE0000 + 32'(i), 4'hF, (i == 2));
    end
    chk("burst3_wr_ready", 64'(wr_ready), 64'd0);
    chk("burst3_level", 64'(level), 64'd3);
    rd_ready = 1'b1;
    tick(); tick(); tick();
    rd_ready = 1'b0;
    chk("burst3_done_wr_ready", 64'(wr_ready), 64'd1);
    chk("burst3_done_rd_valid", 64'(rd_valid), 64'd0);

    // Back in IDLE, DIR is latched afresh
    DIR = 1'b1;
    push_sw(32'hDEADBEEF, 4'b1000, 32'hEFBEADDE, 4'b0001, 1'b0);
    write(32'hDEADBEEF, 4'b1000, 1'b0);
    DIR = 1'b0;
    push_sw(32'h0000FF01, 4'b0101, 32'h01FF0000, 4'b1010, 1'b1);
    write(32'h0000FF01, 4'b0101, 1'b1);
    rd_ready = 1'b1;
    tick(); tick();
    rd_ready = 1'b0;

    // Fill to DEPTH, then one write too many
    for (int i = 0; i < 8; i++) begin
      push(32'h10000000 + 32'(i), 4'hF, 1'b0);
      write(32'h10000000 + 32'(i), 4'hF, 1'b0);
      chk("fill_level", 64'(level), 64'(i + 1));
      chk("fill_almost_full", 64'(almost_full), 64'((i + 1) >= 6));
    end
    chk("full_wr_ready", 64'(wr_ready), 64'd0);
    write(32'h99999999, 4'hF, 1'b0);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_level", 64'(level), 64'd8);

    // Full with simultaneous read and write: only the read completes
    wr_valid = 1'b1; wr_data = 32'h77777777; wr_be = 4'hF; rd_ready = 1'b1;
    chk("full_rw_wr_ready", 64'(wr_ready), 64'd0);
    tick();
    wr_valid = 1'b0; rd_ready = 1'b0;
    chk("full_rw_level", 64'(level), 64'd7);
    chk("full_rw_overflow", 64'(overflow), 64'd1);
    chk("full_rw_wr_ready_next", 64'(wr_ready), 64'd1);

    // Down to five entries, then FLUSH alongside a write
    rd_ready = 1'b1;
    tick(); tick();
    rd_ready = 1'b0;
    chk("pre_flush_level", 64'(level), 64'd5);
    FLUSH = 1'b1;
    write(32'hBAD0BAD0, 4'hF, 1'b0);
    FLUSH = 1'b0;
    sb.delete();
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_rd_valid", 64'(rd_valid), 64'd0);
    chk("flush_overflow", 64'(overflow), 64'd0);
    chk("flush_wr_ready", 64'(wr_ready), 64'd1);

    // RESET mid-burst with dir_q=1
    DIR = 1'b1;
    for (int i = 0; i < 4; i++) begin
      write(32'h20000000 + 32'(i), 4'hF, 1'b0);
    end
    chk("midburst_level", 64'(level), 64'd4);
    RESET = 1'b1;
    DIR = 1'b0;
    tick();
    RESET = 1'b0;
    check_reset_outputs("midreset");

    // Post-reset traffic passes through, and a concurrent write+read holds the level
    push(32'h01020304, 4'b0001, 1'b0);
    write(32'h01020304, 4'b0001, 1'b0);
    push(32'h0A0B0C0D, 4'b0011, 1'b0);
    write(32'h0A0B0C0D, 4'b0011, 1'b0);
    chk("post_reset_level", 64'(level), 64'd2);
    push(32'h55AA55AA, 4'hF, 1'b0);
    rd_ready = 1'b1;
    write(32'h55AA55AA, 4'hF, 1'b0);
    chk("rw_level_hold", 64'(level), 64'd2);
    tick(); tick();
    rd_ready = 1'b0;
    chk("final_rd_valid", 64'(rd_valid), 64'd0);
    chk("final_level", 64'(level), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pci_burst_fifo.md
PCI_BURST_FIFO -- requirements
Module: pci_burst_fifo

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of 2, minimum 2.
REQ-003 Parameter AFULL_LVL, default DEPTH-2, level at or above which almost_full asserts.
REQ-004 CLKP  in  1  sole clock; all state changes on the rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 DIR  in  1  transfer direction: 0 = PCI->Amiga, 1 = Amiga->PCI; sampled only in IDLE.
REQ-007 FLUSH  in  1  synchronous clear of contents and return to IDLE.
REQ-008 wr_valid  in  1  producer presents a word.
REQ-009 wr_last  in  1  qualifies wr_valid: the word is the last of the burst.
REQ-010 wr_data  in  DATA_W  write word.
REQ-011 wr_be  in  DATA_W/8  byte enables, 1 = lane valid.
REQ-012 wr_ready  out  1  FIFO accepts a word this cycle.
REQ-013 rd_valid  out  1  rd_data/rd_be hold a valid word.
REQ-014 rd_ready  in  1  consumer takes the word.
REQ-015 rd_data  out  DATA_W  read word, byte-ordered per REQ-027.
REQ-016 rd_be  out  DATA_W/8  read byte enables, ordered like rd_data.
REQ-017 rd_last  out  1  current read word is the last of the burst.
REQ-018 level  out  clog2(DEPTH)+1  entries stored.
REQ-019 almost_full  out  1  level >= AFULL_LVL.
REQ-020 overflow  out  1  sticky error flag.

Function
REQ-021 Write handshake SHALL complete on wr_valid && wr_ready; read handshake SHALL complete on rd_valid && rd_ready.
REQ-022 wr_ready SHALL be !full && state != DRAIN; when full, a same-cycle read SHALL NOT make wr_ready high in that cycle.
REQ-023 rd_valid SHALL be high whenever level > 0; a word written in cycle N SHALL appear on rd_data in cycle N+1, first-word fall-through.
REQ-024 On a simultaneous write and read, level SHALL remain unchanged and both pointers SHALL advance.
REQ-025 Pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0; level SHALL never exceed DEPTH or underflow below 0.
REQ-026 FSM states SHALL be IDLE, ACTIVE and DRAIN:
  - IDLE->ACTIVE on the first accepted write; DIR is latched into dir_q on that same cycle.
  - ACTIVE->DRAIN on an accepted write with wr_last=1.
  - DRAIN->IDLE when the word flagged last is read.
REQ-027 When dir_q=1 and the swap is compiled in, rd_data and rd_be SHALL be fully byte-reversed (lane i -> lane DATA_W/8-1-i); when dir_q=0, they SHALL pass through unchanged.
REQ-028 Changes on DIR outside IDLE SHALL be ignored.
REQ-029 wr_valid while wr_ready=0 SHALL set overflow; the word SHALL be discarded and FIFO state SHALL be unchanged.
REQ-030 FLUSH SHALL have priority over read and write in the same cycle:
  - next cycle: level=0, pointers=0, state=IDLE, overflow=0;
  - write or read handshakes in the FLUSH cycle are discarded.
REQ-031 almost_full SHALL be a combinational compare of the registered level.

Reset
REQ-032 RESET SHALL have priority over FLUSH and all handshakes.
REQ-033 One cycle after RESET is sampled high:
  - state=IDLE, level=0, pointers=0, dir_q=0;
  - wr_ready=1, rd_valid=0, rd_last=0, almost_full=0, overflow=0.
REQ-034 RESET mid-burst SHALL discard all stored words; RAM contents need not be cleared.

Configuration
REQ-035 Macro PCI_BYTE_SWAP_EN defined: byte-lane reversal per REQ-027 SHALL be active.
REQ-036 Macro PCI_BYTE_SWAP_EN undefined: rd_data and rd_be SHALL equal the stored values regardless of dir_q; dir_q SHALL still be latched and the FSM SHALL be unchanged.

Verification
REQ-037 DIR=1, swap compiled in, write 0x11223344 with be=4'b0011 -> next cycle rd_data=0x44332211, rd_be=4'b1100, rd_valid=1.
REQ-038 DEPTH=8: 8 writes with no reads -> level=8, wr_ready=0, almost_full=1 from level 6; a 9th wr_valid sets overflow=1 and level stays 8.
REQ-039 Full FIFO with simultaneous read and wr_valid -> read completes, write is rejected (overflow=1), level=7; next cycle wr_ready=1.
REQ-040 Burst of 3 words with wr_last on the 3rd -> state=DRAIN, wr_ready=0; after 3 reads rd_last=1 on the 3rd and state returns to IDLE.
REQ-041 FLUSH asserted with level=5 and wr_valid=1 -> next cycle level=0, rd_valid=0, state=IDLE, overflow cleared.
REQ-042 RESET asserted mid-burst with level=4, dir_q=1 -> next cycle all outputs per REQ-033; a subsequent DIR=0 write passes through unswapped.
